// File: rtl/cam_arbiter.sv
// Two-requester front end for a CAM: round-robin grant, one operation in flight,
// fixed accept/strobe/capture/respond pipeline and a free-entry allocator.
module cam_arbiter #(
  parameter  int ENTRIES = 32,
  parameter  int DATA_W  = 32,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             req_valid_i,
  output logic [1:0]             req_ready_o,
  input  logic [1:0][1:0]        req_op_i,
  input  logic [1:0][IDX_W-1:0]  req_index_i,
  input  logic [1:0][DATA_W-1:0] req_data_i,
  output logic [1:0]             rsp_valid_o,
  input  logic [1:0]             rsp_ready_i,
  output logic [DATA_W-1:0]      rsp_data_o,
  output logic [IDX_W-1:0]       rsp_index_o,
  output logic                   rsp_hit_o,
  output logic                   rsp_err_o,
  output logic                   cam_write_enable_o,
  output logic [IDX_W-1:0]       cam_write_index_o,
  output logic [DATA_W-1:0]      cam_write_data_o,
  output logic [IDX_W-1:0]       cam_read_index_o,
  output logic                   cam_search_enable_o,
  output logic [DATA_W-1:0]      cam_search_data_o,
  input  logic [DATA_W-1:0]      cam_read_value_i,
  input  logic                   cam_read_valid_i,
  input  logic [IDX_W-1:0]       cam_search_index_i,
  input  logic                   cam_search_valid_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_SEARCH, OP_ALLOC} op_t;

  state_t              state_q, state_d;
  op_t                 op_q;
  logic                grant_q, grant_d;
  logic                rr_q;
  logic [IDX_W-1:0]    index_q;
  logic [DATA_W-1:0]   data_q;
  logic [ENTRIES-1:0]  occ_q;
  logic [IDX_W-1:0]    alloc_idx_q;
  logic                alloc_fail_q;
  logic [IDX_W-1:0]    free_idx;
  logic                free_found;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [IDX_W-1:0]    rsp_index_q;
  logic                rsp_hit_q;
  logic                rsp_err_q;

  // rr_q names the requester that wins a tie
  always_comb begin
    grant_d = (req_valid_i == 2'b11) ? rr_q : req_valid_i[1];
  end

  // Downward scan so the last assignment is the lowest free entry
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int unsigned i = int'(ENTRIES); i > 0; i--) begin
      if (!occ_q[i-1]) begin
        free_idx   = IDX_W'(i - 1);
        free_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d             = state_q;
    req_ready_o         = '0;
    rsp_valid_o         = '0;
    cam_write_enable_o  = 1'b0;
    cam_write_index_o   = '0;
    cam_write_data_o    = '0;
    cam_read_index_o    = '0;
    cam_search_enable_o = 1'b0;
    cam_search_data_o   = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          req_ready_o[grant_d] = rst_i;
          state_d              = ISSUE;
        end
      end
      ISSUE: begin
        cam_read_index_o = index_q;
        case (op_q)
          OP_WRITE: begin
            cam_write_enable_o = 1'b1;
            cam_write_index_o  = index_q;
            cam_write_data_o   = data_q;
          end
          OP_SEARCH: begin
            cam_search_enable_o = 1'b1;
            cam_search_data_o   = data_q;
          end
          OP_ALLOC: begin
            if (free_found) begin
              cam_write_enable_o = 1'b1;
              cam_write_index_o  = free_idx;
              cam_write_data_o   = data_q;
            end
          end
          default: ;
        endcase
        state_d = CAPTURE;
      end
      CAPTURE: begin
        cam_read_index_o = index_q;
        state_d          = RESP;
      end
      RESP: begin
        rsp_valid_o[grant_q] = 1'b1;
        if (rsp_ready_i[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      grant_q      <= 1'b0;
      rr_q         <= 1'b0;
      op_q         <= OP_READ;
      index_q      <= '0;
      data_q       <= '0;
      occ_q        <= '0;
      alloc_idx_q  <= '0;
      alloc_fail_q <= 1'b0;
      rsp_data_q   <= '0;
      rsp_index_q  <= '0;
      rsp_hit_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && |req_valid_i) begin
        grant_q <= grant_d;
        rr_q    <= ~grant_d;
        op_q    <= op_t'(req_op_i[grant_d]);
        index_q <= req_index_i[grant_d];
        data_q  <= req_data_i[grant_d];
      end
      if (cam_write_enable_o) occ_q[cam_write_index_o] <= 1'b1;
      if (state_q == ISSUE) begin
        alloc_idx_q  <= free_idx;
        alloc_fail_q <= ~free_found;
      end
      if (state_q == CAPTURE) begin
        rsp_data_q  <= '0;
        rsp_index_q <= '0;
        rsp_hit_q   <= 1'b0;
        rsp_err_q   <= 1'b0;
        case (op_q)
          OP_READ: begin
            rsp_data_q <= cam_read_value_i;
            rsp_hit_q  <= cam_read_valid_i;
          end
          OP_SEARCH: begin
            rsp_index_q <= cam_search_index_i;
            rsp_hit_q   <= cam_search_valid_i;
          end
          OP_ALLOC: begin
            rsp_index_q <= alloc_fail_q ? '0 : alloc_idx_q;
            rsp_err_q   <= alloc_fail_q;
          end
          default: ;
        endcase
      end
    end
  end

  assign rsp_data_o  = rsp_data_q;
  assign rsp_index_o = rsp_index_q;
  assign rsp_hit_o   = rsp_hit_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: doc/cam_arbiter.md
CAM_ARBITER -- requirements
Module: cam_arbiter

Interface
REQ-001 SHALL have parameter ENTRIES, default 32, number of CAM entries.
REQ-002 SHALL have parameter DATA_W, default 32, CAM word width; IDX_W = $clog2(ENTRIES).
REQ-003 SHALL have port clk_i, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid_i, input, 2, per-requester request valid.
REQ-006 SHALL have port req_ready_o, output, 2, per-requester accept strobe.
REQ-007 SHALL have port req_op_i, input, 2x2, per-requester op: 00 read, 01 write, 10 search, 11 write-alloc.
REQ-008 SHALL have port req_index_i, input, 2xIDX_W, per-requester target index (read, write).
REQ-009 SHALL have port req_data_i, input, 2xDATA_W, per-requester write or search data.
REQ-010 SHALL have port rsp_valid_o, output, 2, per-requester response valid.
REQ-011 SHALL have port rsp_ready_i, input, 2, per-requester response accept.
REQ-012 SHALL have port rsp_data_o, output, DATA_W, shared read data.
REQ-013 SHALL have port rsp_index_o, output, IDX_W, shared search hit index or allocated index.
REQ-014 SHALL have port rsp_hit_o, output, 1, shared read valid or search hit.
REQ-015 SHALL have port rsp_err_o, output, 1, shared write-alloc failure (CAM full).
REQ-016 SHALL have CAM-side ports cam_write_enable_o (1), cam_write_index_o (IDX_W), cam_write_data_o (DATA_W), cam_read_index_o (IDX_W), cam_search_enable_o (1), cam_search_data_o (DATA_W), all outputs.
REQ-017 SHALL have CAM-side ports cam_read_value_i (DATA_W), cam_read_valid_i (1), cam_search_index_i (IDX_W), cam_search_valid_i (1), all inputs.

Function
REQ-018 SHALL implement FSM with states IDLE, ISSUE, CAPTURE, RESP; exactly one operation is in flight at a time.
REQ-019 IDLE: SHALL grant when any req_valid_i is set, pulse req_ready_o[grant] high for that single cycle, latch op/index/data, and go to ISSUE.
REQ-020 Arbitration SHALL be round-robin: on a tie, the requester not granted last wins; after reset, requester 0 wins the first tie.
REQ-021 ISSUE (one cycle): write SHALL assert cam_write_enable_o at the latched index; search SHALL assert cam_search_enable_o with latched data; read SHALL assert no strobe.
REQ-022 cam_read_index_o SHALL hold the latched index through ISSUE and CAPTURE.
REQ-023 CAPTURE (one cycle): SHALL register cam_read_value_i/cam_read_valid_i (read) or cam_search_index_i/cam_search_valid_i (search) into the response registers, then go to RESP.
REQ-024 RESP: SHALL hold rsp_valid_o[grant] high with stable response fields until rsp_ready_i[grant] is high, then return to IDLE in the next cycle.
REQ-025 Latency SHALL be: request accepted in cycle T, CAM strobe in T+1, capture in T+2, rsp_valid_o high from T+3.
REQ-026 SHALL keep an ENTRIES-bit occupancy bitmap; each write or write-alloc issued sets the bit of the target index.
REQ-027 Write-alloc SHALL pick the lowest index with a clear occupancy bit at ISSUE, write there, and return that index on rsp_index_o with rsp_err_o=0.
REQ-028 When all bits are set, write-alloc SHALL issue no strobe and SHALL respond with rsp_err_o=1 and rsp_index_o=0.
REQ-029 For plain write, rsp_hit_o, rsp_err_o and rsp_index_o SHALL be 0; a write to an occupied index SHALL overwrite it.
REQ-030 For read and search, unused response fields SHALL be 0.
REQ-031 New requests arriving while the FSM is not in IDLE SHALL stall with req_ready_o low; an un-granted pending request SHALL be granted at the next IDLE.
REQ-032 cam_write_enable_o and cam_search_enable_o SHALL never be high in the same cycle, and never outside ISSUE.

Reset
REQ-033 Asserting rst_i low SHALL immediately force IDLE and clear the occupancy bitmap, the round-robin pointer (to favour 0) and all response registers.
REQ-034 During reset, all outputs SHALL be 0.
REQ-035 Reset asserted mid-operation SHALL abort the operation with no response and no CAM strobe after reset deasserts.

Verification
REQ-036 Req0 write idx 5 data 0xDEADBEEF, then req0 read idx 5 -> cam_write_enable_o pulses in T+1 and the read response returns rsp_data_o=0xDEADBEEF, rsp_hit_o=1 at T+3.
REQ-037 Req0 and req1 both search in the same cycle, repeated twice -> grants go 0, 1, 0, 1 and each requester receives only its own rsp_valid_o.
REQ-038 33 write-allocs on an empty CAM -> returned indices are 0 through 31 in order, then the 33rd returns rsp_err_o=1 with no write strobe.
REQ-039 Req1 holds rsp_ready_i low for 10 cycles -> response fields stay stable, req0 stays stalled with req_ready_o[0]=0, then req0 is granted the cycle after IDLE is re-entered.
REQ-040 rst_i pulsed low during CAPTURE of a search -> no response is produced, the bitmap is empty, and the next write-alloc returns index 0.
